conv_window_scheduler: RTL and testbench

- Sequences the shared main-memory RAM for one convolution layer.
- Walks the output feature map in raster order. For each output pixel it:
  - fetches the 5x5 input window (one RAM read, row pitch given by the offset port);
  - hands the window to the convolution unit;
  - waits for the scalar result;
  - writes the result back to RAM.
- It is the only master of the RAM enable/write/address/offset/input_data pins and arbitrates read and write traffic over that single port.

---
 rtl/conv_window_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// Convolution layer scheduler: walks the output map in raster order and
// arbitrates window reads and result writes over the single RAM port.
module conv_window_scheduler #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] in_width,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [DIM_W-1:0]  out_rows,
    input  logic [DIM_W-1:0]  out_cols,
    input  logic [1:0]        stride,
    output logic              ram_enable,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [ADDR_W-1:0] ram_offset,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_finish,
    output logic              win_valid,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_result,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_GAP, COMPUTE, WR_REQ, WR_GAP, DONE
    } state_t;

    localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO_A = ADDR_W'(2);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] width_q;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DIM_W-1:0]  rows_q;
    logic [DIM_W-1:0]  cols_q;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic              step2;
    logic [DATA_W-1:0] wdata_q;
    logic              res_ok;

    logic              last_col;
    logic              last_pix;
    logic [ADDR_W-1:0] col_step;
    logic [ADDR_W-1:0] row_step;
    logic [ADDR_W-1:0] row_next;
    logic              empty_cfg;

    assign last_col  = (col == cols_q - ONE_D);
    assign last_pix  = last_col && (row == rows_q - ONE_D);
    assign col_step  = step2 ? TWO_A : ONE_A;
    assign row_step  = step2 ? {width_q[ADDR_W-2:0], 1'b0} : width_q;
    assign row_next  = row_addr + row_step;
    assign empty_cfg = (out_rows == '0) || (out_cols == '0);
    assign ram_wdata = wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = empty_cfg ? DONE : RD_REQ;
            end
            RD_REQ:  if (ram_finish) state_nxt = RD_GAP;
            RD_GAP:  state_nxt = COMPUTE;
            COMPUTE: if (conv_done || res_ok) state_nxt = WR_REQ;
            WR_REQ:  if (ram_finish) state_nxt = WR_GAP;
            WR_GAP:  state_nxt = last_pix ? DONE : RD_REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        ram_enable  = 1'b0;
        ram_write   = 1'b0;
        ram_address = '0;
        ram_offset  = '0;
        win_valid   = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        unique case (state)
            IDLE: ;
            RD_REQ: begin
                ram_enable  = 1'b1;
                ram_address = rd_addr;
                ram_offset  = width_q;
                busy        = 1'b1;
            end
            RD_GAP: begin
                win_valid = 1'b1;
                busy      = 1'b1;
            end
            COMPUTE: busy = 1'b1;
            WR_REQ: begin
                ram_enable  = 1'b1;
                ram_write   = 1'b1;
                ram_address = wr_addr;
                busy        = 1'b1;
            end
            WR_GAP: busy = 1'b1;
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

    // Config latch, raster counters, address walk and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            width_q  <= '0;
            row_addr <= '0;
            rd_addr  <= '0;
            wr_addr  <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            row      <= '0;
            col      <= '0;
            step2    <= 1'b0;
            wdata_q  <= '0;
            res_ok   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        width_q  <= in_width;
                        row_addr <= in_base;
                        rd_addr  <= in_base;
                        wr_addr  <= out_base;
                        rows_q   <= out_rows;
                        cols_q   <= out_cols;
                        row      <= '0;
                        col      <= '0;
                        step2    <= (stride == 2'd2);
                        res_ok   <= 1'b0;
                    end
                end
                RD_GAP, COMPUTE: begin
                    if (conv_done) begin
                        wdata_q <= conv_result;
                        res_ok  <= 1'b1;
                    end
                end
                WR_REQ: res_ok <= 1'b0;
                WR_GAP: begin
                    if (!last_pix) begin
                        wr_addr <= wr_addr + ONE_A;
                        if (last_col) begin
                            col      <= '0;
                            row      <= row + ONE_D;
                            row_addr <= row_next;
                            rd_addr  <= row_next;
                        end else begin
                            col     <= col + ONE_D;
                            rd_addr <= rd_addr + col_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler with behavioural RAM and
// conv-unit models and an address/data reference computed from raster math.
module tb_conv_window_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_base = '0;
    logic [15:0] in_width = '0;
    logic [15:0] out_base = '0;
    logic [7:0]  out_rows = '0;
    logic [7:0]  out_cols = '0;
    logic [1:0]  stride = '0;
    logic        ram_enable;
    logic        ram_write;
    logic [15:0] ram_address;
    logic [15:0] ram_offset;
    logic [15:0] ram_wdata;
    logic        ram_finish = 1'b0;
    logic        win_valid;
    logic        conv_done = 1'b0;
    logic [15:0] conv_result = '0;
    logic        busy;
    logic        done;

    conv_window_scheduler #(
        .ADDR_W(16), .DATA_W(16), .DIM_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_base(in_base), .in_width(in_width), .out_base(out_base),
        .out_rows(out_rows), .out_cols(out_cols), .stride(stride),
        .ram_enable(ram_enable), .ram_write(ram_write),
        .ram_address(ram_address), .ram_offset(ram_offset),
        .ram_wdata(ram_wdata), .ram_finish(ram_finish),
        .win_valid(win_valid), .conv_done(conv_done),
        .conv_result(conv_result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RAM model: finish rises fin_lat cycles into an access, clears on enable low
    int fin_lat = 0;
    int en_cnt = 0;
    always @(posedge clk) begin
        if (!ram_enable) begin
            en_cnt     <= 0;
            ram_finish <= 1'b0;
        end else begin
            en_cnt <= en_cnt + 1;
            if (en_cnt >= fin_lat) ram_finish <= 1'b1;
        end
    end

    // Conv unit model: result conv_lat cycles after the window (0 = same cycle)
    int          conv_lat = 1;
    int          cv_cnt = 0;
    bit          use_fixed = 1'b0;
    logic [15:0] fixed_val = '0;
    logic [15:0] res_q[$];
    always @(negedge clk) begin
        logic [15:0] v;
        conv_done = 1'b0;
        if (cv_cnt > 0) begin
            cv_cnt--;
            if (cv_cnt == 0) conv_done = 1'b1;
        end
        if (win_valid) begin
            v = use_fixed ? fixed_val : 16'($urandom);
            res_q.push_back(v);
            conv_result = v;
            if (conv_lat == 0) conv_done = 1'b1;
            else cv_cnt = conv_lat;
        end
    end

    // Bus monitor: logs each access, tracks stability and protocol
    logic        acc_w[$];
    logic [15:0] acc_a[$];
    logic [15:0] acc_o[$];
    logic [15:0] acc_d[$];
    logic        prev_en = 1'b0;
    logic        s_w;
    logic [15:0] s_a, s_o, s_d;
    int stab_viol = 0;
    int proto_viol = 0;
    int done_cnt = 0;
    int win_cnt = 0;
    int en_cycles = 0;
    int busy_cycles = 0;
    always @(negedge clk) begin
        if (ram_enable) en_cycles++;
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (win_valid) win_cnt++;
        if (ram_enable && !prev_en) begin
            acc_w.push_back(ram_write);
            acc_a.push_back(ram_address);
            acc_o.push_back(ram_offset);
            acc_d.push_back(ram_wdata);
            s_w = ram_write; s_a = ram_address;
            s_o = ram_offset; s_d = ram_wdata;
        end else if (ram_enable) begin
            if (ram_write !== s_w || ram_address !== s_a ||
                ram_offset !== s_o || ram_wdata !== s_d)
                stab_viol++;
        end
        if ((ram_enable && !busy) || (done && busy) ||
            (win_valid && ram_enable))
            proto_viol++;
        prev_en = ram_enable;
    end

    // Reference: accesses alternate read/write, one pair per output pixel
    function automatic int n_bad(input logic [15:0] ib, input logic [15:0] iw,
                                 input logic [15:0] ob, input int r,
                                 input int c, input int s);
        int st = (s == 2) ? 2 : 1;
        int n = 0;
        int k = 0;
        if (acc_w.size() != 2 * r * c) return -1;
        if (res_q.size() != r * c) return -2;
        for (int y = 0; y < r; y++) begin
            for (int x = 0; x < c; x++) begin
                logic [15:0] ea;
                logic [15:0] ew;
                ea = 16'(ib + y * iw * st + x * st);
                ew = 16'(ob + k / 2);
                if (acc_w[k] !== 1'b0 || acc_a[k] !== ea || acc_o[k] !== iw)
                    n++;
                if (acc_w[k+1] !== 1'b1 || acc_a[k+1] !== ew ||
                    acc_d[k+1] !== res_q[k/2])
                    n++;
                k += 2;
            end
        end
        return n;
    endfunction

    task automatic kick(input logic [15:0] ib, input logic [15:0] iw,
                        input logic [15:0] ob, input logic [7:0] r,
                        input logic [7:0] c, input logic [1:0] s);
        acc_w.delete(); acc_a.delete(); acc_o.delete(); acc_d.delete();
        res_q.delete();
        stab_viol = 0; proto_viol = 0; done_cnt = 0; win_cnt = 0;
        en_cycles = 0; busy_cycles = 0; cv_cnt = 0;
        in_base = ib; in_width = iw; out_base = ob;
        out_rows = r; out_cols = c; stride = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit to);
        cyc = 0;
        to = 1'b1;
        while (cyc < budget) begin
            #1;
            if (done_cnt > 0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cyc;
        bit to;
        int nb;
        bit hit;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_enable, ram_write, win_valid, busy, done} !== 5'b0 ||
            ram_address !== 16'h0 || ram_offset !== 16'h0 ||
            ram_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b wr=%b addr=%h off=%h wd=%h busy=%b done=%b want all 0",
                     ram_enable, ram_write, ram_address, ram_offset,
                     ram_wdata, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        kick(16'd7, 16'd16, 16'd900, 8'd2, 8'd2, 2'd1);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ram_enable && ram_write) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_reach_wr: got no write access want one within 200 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_layer: got en=%b busy=%b done=%b want 0 0 0",
                     ram_enable, busy, done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        kick(16'd7, 16'd16, 16'd900, 8'd2, 8'd2, 2'd1);
        wait_done(500, cyc, to);
        nb = n_bad(16'd7, 16'd16, 16'd900, 2, 2, 1);
        checks++;
        if (to || nb != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL reset_rerun: got timeout=%0d bad=%0d done=%0d want 0 0 1",
                     to, nb, done_cnt);
        end
    endtask

    task automatic test_single_pixel();
        int cyc;
        bit to;
        int en_after;
        use_fixed = 1'b1;
        fixed_val = 16'h1234;
        kick(16'd0, 16'd32, 16'd50692, 8'd1, 8'd1, 2'd1);
        wait_done(200, cyc, to);
        en_after = en_cycles;
        repeat (6) @(negedge clk);
        #1;
        use_fixed = 1'b0;
        checks++;
        if (to || acc_w.size() != 2) begin
            errors++;
            $display("FAIL single_count: got timeout=%0d accesses=%0d want 0 2",
                     to, acc_w.size());
        end else begin
            checks++;
            if (acc_w[0] !== 1'b0 || acc_a[0] !== 16'd0 ||
                acc_o[0] !== 16'd32) begin
                errors++;
                $display("FAIL single_read: got wr=%b addr=%0d off=%0d want 0 0 32",
                         acc_w[0], acc_a[0], acc_o[0]);
            end
            checks++;
            if (acc_w[1] !== 1'b1 || acc_a[1] !== 16'd50692 ||
                acc_d[1] !== 16'h1234) begin
                errors++;
                $display("FAIL single_write: got wr=%b addr=%0d data=%h want 1 50692 1234",
                         acc_w[1], acc_a[1], acc_d[1]);
            end
        end
        checks++;
        if (win_cnt != 1 || done_cnt != 1 || en_cycles != en_after) begin
            errors++;
            $display("FAIL single_pulses: got win=%0d done=%0d late_en=%0d want 1 1 0",
                     win_cnt, done_cnt, en_cycles - en_after);
        end
    endtask

    task automatic test_raster();
        int cyc;
        bit to;
        int nb;
        kick(16'd100, 16'd10, 16'd3000, 8'd2, 8'd3, 2'd1);
        wait_done(1000, cyc, to);
        nb = n_bad(16'd100, 16'd10, 16'd3000, 2, 3, 1);
        checks++;
        if (to || nb != 0) begin
            errors++;
            $display("FAIL raster_2x3: got timeout=%0d bad=%0d want 0 0", to, nb);
        end
        checks++;
        if (proto_viol != 0 || stab_viol != 0) begin
            errors++;
            $display("FAIL raster_protocol: got proto=%0d stab=%0d want 0 0",
                     proto_viol, stab_viol);
        end
    endtask

    task automatic test_stride2();
        int cyc;
        bit to;
        int nb;
        kick(16'd0, 16'd20, 16'd500, 8'd2, 8'd2, 2'd2);
        wait_done(1000, cyc, to);
        nb = n_bad(16'd0, 16'd20, 16'd500, 2, 2, 2);
        checks++;
        if (to || nb != 0) begin
            errors++;
            $display("FAIL stride2_2x2: got timeout=%0d bad=%0d want 0 0", to, nb);
        end
    endtask

    task automatic test_zero_dim();
        int cyc;
        bit to;
        kick(16'd5, 16'd8, 16'd77, 8'd3, 8'd0, 2'd1);
        wait_done(10, cyc, to);
        checks++;
        if (to || cyc > 2 || en_cycles != 0 || busy_cycles != 0 ||
            done_cnt != 1) begin
            errors++;
            $display("FAIL zero_cols: got timeout=%0d lat=%0d en=%0d busy=%0d done=%0d want 0 <=2 0 0 1",
                     to, cyc, en_cycles, busy_cycles, done_cnt);
        end
    endtask

    task automatic test_handshake_delay();
        int cyc;
        bit to;
        int nb;
        fin_lat = 5;
        conv_lat = 7;
        kick(16'd40, 16'd9, 16'd1000, 8'd1, 8'd2, 2'd1);
        wait_done(2000, cyc, to);
        nb = n_bad(16'd40, 16'd9, 16'd1000, 1, 2, 1);
        checks++;
        if (to || nb != 0 || stab_viol != 0 || en_cycles < 24) begin
            errors++;
            $display("FAIL slow_handshake: got timeout=%0d bad=%0d stab=%0d en=%0d want 0 0 0 >=24",
                     to, nb, stab_viol, en_cycles);
        end
        fin_lat = 0;
        conv_lat = 0;
        kick(16'd11, 16'd4, 16'd2000, 8'd2, 8'd2, 2'd1);
        wait_done(1000, cyc, to);
        nb = n_bad(16'd11, 16'd4, 16'd2000, 2, 2, 1);
        checks++;
        if (to || nb != 0) begin
            errors++;
            $display("FAIL early_conv_done: got timeout=%0d bad=%0d want 0 0", to, nb);
        end
        conv_lat = 1;
    endtask

    task automatic test_start_while_busy();
        int cyc;
        bit to;
        int nb;
        kick(16'd200, 16'd12, 16'd4000, 8'd2, 8'd2, 2'd1);
        repeat (5) @(negedge clk);
        in_base = 16'd9; in_width = 16'd3; out_base = 16'd1;
        out_rows = 8'd4; out_cols = 8'd4; stride = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000, cyc, to);
        repeat (10) @(negedge clk);
        #1;
        nb = n_bad(16'd200, 16'd12, 16'd4000, 2, 2, 1);
        checks++;
        if (to || nb != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL start_while_busy: got timeout=%0d bad=%0d done=%0d want 0 0 1",
                     to, nb, done_cnt);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit to;
        int nb;
        for (int it = 0; it < 8; it++) begin
            logic [15:0] ib, iw, ob;
            logic [7:0]  r, c;
            logic [1:0]  s;
            ib = 16'($urandom);
            iw = 16'($urandom_range(1, 300));
            ob = 16'($urandom);
            r  = 8'($urandom_range(1, 3));
            c  = 8'($urandom_range(1, 4));
            s  = 2'($urandom_range(0, 2));
            fin_lat  = $urandom_range(0, 3);
            conv_lat = $urandom_range(0, 4);
            kick(ib, iw, ob, r, c, s);
            wait_done(3000, cyc, to);
            nb = n_bad(ib, iw, ob, int'(r), int'(c), int'(s));
            checks++;
            if (to || nb != 0 || proto_viol != 0 || stab_viol != 0 ||
                win_cnt != int'(r) * int'(c)) begin
                errors++;
                $display("FAIL random_%0d: got timeout=%0d bad=%0d proto=%0d stab=%0d win=%0d want 0 0 0 0 %0d",
                         it, to, nb, proto_viol, stab_viol, win_cnt,
                         int'(r) * int'(c));
            end
        end
        fin_lat = 0;
        conv_lat = 1;
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_raster();
        test_stride2();
        test_zero_dim();
        test_handshake_delay();
        test_start_while_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
